// File: rtl/user_sw_pkg.sv
// user_sw_pkg: shared FSM states, width helper and default constants for the switch debouncer.
package user_sw_pkg;
  typedef enum logic [1:0] {OFF, CHK_ON, ON, CHK_OFF} sw_state_e;
  localparam int DEF_CLK_KHZ = 125000;
  localparam int DEF_TICK_MS = 1;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sw_debounce_ch.sv
// sw_debounce_ch: one switch channel - 2-FF synchroniser, polarity fix, debounce FSM, long-press counter.
module sw_debounce_ch
  import user_sw_pkg::*;
#(
  parameter int pDebTicks  = 8,
  parameter int pLongTicks = 1000,
  parameter bit pPol       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clr,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);
  localparam int DW = cw(pDebTicks + 1);
  localparam int LW = cw(pLongTicks + 1);
  localparam logic [DW-1:0] DLAST = DW'(pDebTicks - 1);
  localparam logic [LW-1:0] LMAX = LW'(pLongTicks);
  logic [1:0] sync;
  logic s;
  sw_state_e state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic level_n, rise_n, fall_n, long_n;
  assign s = sync[1] ^ pPol;
  // an input change always beats a coincident tick: it returns to the stable state first
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    level_n = level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    lcnt_n  = ((state == ON || state == CHK_OFF) && tick && lcnt != LMAX) ? lcnt + LW'(1) : lcnt;
    case (state)
      OFF: if (s) begin state_n = CHK_ON; dcnt_n = '0; end
      CHK_ON:
        if (!s) begin state_n = OFF; dcnt_n = '0; end
        else if (tick && dcnt == DLAST) begin state_n = ON; dcnt_n = '0; level_n = 1'b1; rise_n = 1'b1; end
        else if (tick) dcnt_n = dcnt + DW'(1);
      ON: if (!s) begin state_n = CHK_OFF; dcnt_n = '0; end
      CHK_OFF:
        if (s) begin state_n = ON; dcnt_n = '0; end
        else if (tick && dcnt == DLAST) begin state_n = OFF; dcnt_n = '0; lcnt_n = '0; level_n = 1'b0; fall_n = 1'b1; end
        else if (tick) dcnt_n = dcnt + DW'(1);
      default: state_n = OFF;
    endcase
    long_n = (lcnt_n == LMAX) && (lcnt != LMAX);
    if (clr) begin
      state_n = OFF;
      dcnt_n  = '0;
      lcnt_n  = '0;
      level_n = 1'b0;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      long_n  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync       <= '0;
      state      <= OFF;
      dcnt       <= '0;
      lcnt       <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      sync       <= {sync[0], sw};
      state      <= state_n;
      dcnt       <= dcnt_n;
      lcnt       <= lcnt_n;
      level      <= level_n;
      rise       <= rise_n;
      fall       <= fall_n;
      long_press <= long_n;
    end
endmodule

// File: rtl/user_sw_debounce_array.sv
// user_sw_debounce_array: shared debounce tick divider feeding pChNum independent switch channels.
module user_sw_debounce_array
  import user_sw_pkg::*;
#(
  parameter int pChNum     = 8,
  parameter int pSysClkKhz = DEF_CLK_KHZ,
  parameter int pTickMs    = DEF_TICK_MS,
  parameter int pDebTicks  = 8,
  parameter int pLongTicks = 1000,
  parameter logic [pChNum-1:0] pPolMask = '0
) (
  input  logic              iSysClk,
  input  logic              iSysRst,
  input  logic [pChNum-1:0] iUserSw,
  input  logic              iClr,
  output logic [pChNum-1:0] oSwLevel,
  output logic [pChNum-1:0] oSwRise,
  output logic [pChNum-1:0] oSwFall,
  output logic [pChNum-1:0] oSwLong,
  output logic              oTick
);
  localparam int TDIV = pSysClkKhz * pTickMs;
  localparam int TW = cw(TDIV);
  localparam logic [TW-1:0] TLAST = TW'(TDIV - 1);
  logic [TW-1:0] tcnt;
  assign oTick = tcnt == TLAST;
  // free-running: iClr deliberately leaves the tick phase alone
  always_ff @(posedge iSysClk or negedge iSysRst)
    if (!iSysRst) tcnt <= '0;
    else tcnt <= oTick ? '0 : tcnt + TW'(1);
  for (genvar i = 0; i < pChNum; i++) begin : g_ch
    sw_debounce_ch #(
      .pDebTicks (pDebTicks),
      .pLongTicks(pLongTicks),
      .pPol      (pPolMask[i])
    ) u_ch (
      .clk       (iSysClk),
      .rst_n     (iSysRst),
      .tick      (oTick),
      .clr       (iClr),
      .sw        (iUserSw[i]),
      .level     (oSwLevel[i]),
      .rise      (oSwRise[i]),
      .fall      (oSwFall[i]),
      .long_press(oSwLong[i])
    );
  end
endmodule

// File: tb/tb_user_sw_debounce_array.sv
// tb_user_sw_debounce_array: directed vector table plus hand sequences for the 4-channel debouncer.
module tb_user_sw_debounce_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sw = 4'b0100;
  logic clr = 1'b0;
  logic [3:0] level, rise, fall, lng;
  logic tick;
  int tests = 0;
  int fails = 0;
  int cyc;
  int rc[4], fc[4], lc[4], rb[4], fb[4], lb[4];
  int rcyc[4], fcyc[4], lcyc[4];
  int k;
  int ph[3];
  typedef struct {
    logic [3:0] sw;
    int         hold;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] lng;
  } vec_t;
  vec_t vt[10];

  user_sw_debounce_array #(
    .pChNum    (4),
    .pSysClkKhz(10),
    .pTickMs   (1),
    .pDebTicks (4),
    .pLongTicks(20),
    .pPolMask  (4'b0100)
  ) dut (
    .iSysClk (clk),
    .iSysRst (rst_n),
    .iUserSw (sw),
    .iClr    (clr),
    .oSwLevel(level),
    .oSwRise (rise),
    .oSwFall (fall),
    .oSwLong (lng),
    .oTick   (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n) begin
      tests++;
      if (tick !== (cyc % 10 == 9)) begin
        fails++;
        $display("FAIL tick at cyc %0d: got %b expected %b", cyc, tick, cyc % 10 == 9);
      end
      if (|(rise & fall)) begin
        fails++;
        $display("FAIL rise/fall overlap at cyc %0d: rise %b fall %b", cyc, rise, fall);
      end
      for (int c = 0; c < 4; c++) begin
        if (rise[c]) begin rc[c]++; rcyc[c] = cyc; end
        if (fall[c]) begin fc[c]++; fcyc[c] = cyc; end
        if (lng[c]) begin lc[c]++; lcyc[c] = cyc; end
      end
    end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic snap();
    rb = rc;
    fb = fc;
    lb = lc;
  endtask

  // pin change at cycle k reaches the FSM at edge k+3; acceptance is the 4th later tick
  function automatic int exp_at(input int kk);
    return ((kk + 3) / 10 + 4) * 10;
  endfunction

  initial begin
    vt[0] = '{4'b0101, 60,  4'b0001, 4'b0001, 4'b0000, 4'b0000};
    vt[1] = '{4'b0100, 60,  4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vt[2] = '{4'b0000, 60,  4'b0100, 4'b0100, 4'b0000, 4'b0000};
    vt[3] = '{4'b0100, 60,  4'b0000, 4'b0000, 4'b0100, 4'b0000};
    vt[4] = '{4'b1100, 60,  4'b1000, 4'b1000, 4'b0000, 4'b0000};
    vt[5] = '{4'b1100, 250, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
    vt[6] = '{4'b1100, 100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    vt[7] = '{4'b0100, 60,  4'b0000, 4'b0000, 4'b1000, 4'b0000};
    vt[8] = '{4'b1100, 260, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    vt[9] = '{4'b0100, 60,  4'b0000, 4'b0000, 4'b1000, 4'b0000};
    ph = '{7, 6, 2};
    for (int c = 0; c < 4; c++) begin
      rc[c] = 0; fc[c] = 0; lc[c] = 0; rcyc[c] = -1; fcyc[c] = -1; lcyc[c] = -1;
    end
    step(3);
    chk("reset level", level, 0);
    chk("reset rise", rise, 0);
    chk("reset fall", fall, 0);
    chk("reset long", lng, 0);
    chk("reset tick", tick, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sw = vt[i].sw;
      snap();
      step(vt[i].hold);
      chk($sformatf("v%0d level", i), level, vt[i].lvl);
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("v%0d ch%0d rise", i, c), rc[c] - rb[c], int'(vt[i].rise[c]));
        chk($sformatf("v%0d ch%0d fall", i, c), fc[c] - fb[c], int'(vt[i].fall[c]));
        chk($sformatf("v%0d ch%0d long", i, c), lc[c] - lb[c], int'(vt[i].lng[c]));
      end
    end
    for (int i = 0; i < 3; i++) begin
      while (cyc % 10 != ph[i]) step();
      k = cyc;
      sw[0] = 1'b1;
      snap();
      step(60);
      chk($sformatf("phase%0d rise count", ph[i]), rc[0] - rb[0], 1);
      chk($sformatf("phase%0d rise cycle", ph[i]), rcyc[0], exp_at(k));
      while (cyc % 10 != ph[i]) step();
      k = cyc;
      sw[0] = 1'b0;
      snap();
      step(60);
      chk($sformatf("phase%0d fall count", ph[i]), fc[0] - fb[0], 1);
      chk($sformatf("phase%0d fall cycle", ph[i]), fcyc[0], exp_at(k));
    end
    while (cyc % 10 != 7) step();
    k = cyc;
    sw[0] = 1'b1;
    snap();
    while (cyc != exp_at(k) - 3) step();
    sw[0] = 1'b0;
    step(60);
    chk("drop on accept tick rise", rc[0] - rb[0], 0);
    chk("drop on accept tick fall", fc[0] - fb[0], 0);
    chk("drop on accept tick level", level[0], 0);
    k = cyc;
    sw[3] = 1'b1;
    snap();
    step(260);
    chk("long count", lc[3] - lb[3], 1);
    chk("long cycle", lcyc[3], exp_at(k) + 200);
    sw[3] = 1'b0;
    step(60);
    snap();
    for (int i = 0; i < 14; i++) begin
      sw[1] = (i % 2 == 0);
      step(7);
    end
    chk("bounce rise", rc[1] - rb[1], 0);
    chk("bounce level", level[1], 0);
    k = cyc;
    sw[1] = 1'b1;
    step(60);
    chk("bounce settle rise", rc[1] - rb[1], 1);
    chk("bounce settle cycle", rcyc[1], exp_at(k));
    sw[1] = 1'b0;
    step(60);
    sw = 4'b1100;
    step(60);
    chk("pre-reset ch3 level", level[3], 1);
    sw = 4'b1101;
    step(20);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset level", level, 0);
    chk("async reset tick", tick, 0);
    step(3);
    @(negedge clk);
    #2 rst_n = 1'b1;
    snap();
    step(40);
    chk("post-reset ch0 rise", rc[0] - rb[0], 1);
    chk("post-reset ch0 cycle", rcyc[0], 40);
    chk("post-reset ch3 cycle", rcyc[3], 40);
    chk("post-reset ch3 fall", fc[3] - fb[3], 0);
    step(100);
    snap();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr level", level, 0);
    step(59);
    chk("clr ch0 fall", fc[0] - fb[0], 0);
    chk("clr ch3 fall", fc[3] - fb[3], 0);
    chk("clr ch0 re-rise", rcyc[0], 180);
    chk("clr ch3 re-rise", rcyc[3], 180);
    step(200);
    chk("clr ch0 long count", lc[0] - lb[0], 1);
    chk("clr ch0 long cycle", lcyc[0], 380);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/user_sw_debounce_array.md
Name: user_sw_debounce_array

Overview:
- Parametrised successor of the 4-channel push/slide switch synchroniser.
- Takes pChNum asynchronous switch inputs. Each channel is synchronised, polarity-normalised and debounced with a per-channel FSM.
- Outputs per channel: debounced level, rise/fall one-clock pulses, and a one-shot long-press pulse.
- Sits in the PreProcessor user-switch block between the board pins and the control logic.

Parameters:
- pChNum, 8, number of switch channels (1..32).
- pSysClkKhz, 125000, system clock frequency in kHz.
- pTickMs, 1, debounce sample period in ms; the tick divider is pSysClkKhz*pTickMs clocks.
- pDebTicks, 8, consecutive ticks an input must hold a new value before it is accepted (>=1).
- pLongTicks, 1000, ticks a channel must stay asserted to raise oSwLong (>=1).
- pPolMask, 0, pChNum-bit mask; bit=1 means that channel is active-low at the pin.

Ports:
- iSysClk  in  1  system clock.
- iSysRst  in  1  reset, asynchronous assert, active-low (0 = reset).
- iUserSw  in  pChNum  raw asynchronous switch pins.
- iClr  in  1  synchronous clear: all channels return to OFF with counters zeroed; no pulses are emitted.
- oSwLevel  out  pChNum  debounced level, 1 = pressed/on.
- oSwRise  out  pChNum  one-clock pulse on accepted off->on.
- oSwFall  out  pChNum  one-clock pulse on accepted on->off.
- oSwLong  out  pChNum  one-clock pulse when the on-state reaches pLongTicks.
- oTick  out  1  debounce tick strobe, for observation and test.

Behaviour:
- Reset (iSysRst=0, async): all outputs 0, synchroniser FFs 0, tick divider 0, all FSMs in OFF, all counters 0.
- Synchroniser:
  - 2-FF chain per channel.
  - s = sync2 XOR pPolMask[i].
  - Latency pin->s is 2 clocks.
- Tick:
  - Free-running counter 0..pSysClkKhz*pTickMs-1.
  - oTick=1 for one clock at terminal count, then the counter wraps to 0.
  - iClr does not reset the tick counter.
- Per-channel FSM (states OFF, CHK_ON, ON, CHK_OFF):
  - OFF: s=1 -> CHK_ON, debounce counter dcnt=0.
  - CHK_ON:
    - s=0 on any clock -> OFF (glitch rejected), dcnt=0.
    - s=1 and tick -> dcnt++.
    - When dcnt==pDebTicks-1 and tick with s=1 -> ON. oSwLevel=1 and oSwRise=1 on the following clock.
  - ON: s=0 -> CHK_OFF, dcnt=0. Long-press counter lcnt keeps running.
  - CHK_OFF: mirror of CHK_ON.
    - s=1 -> back to ON; lcnt is not cleared.
    - Acceptance -> OFF, with oSwLevel=0 and oSwFall=1 on the following clock. lcnt=0.
- Long press:
  - In ON or CHK_OFF, lcnt increments on tick and saturates at pLongTicks.
  - oSwLong pulses exactly once, on the clock after lcnt reaches pLongTicks.
  - Cleared only on acceptance of OFF, iClr or reset.
- Simultaneous events:
  - s change and tick in the same clock: the s change wins (return to the stable state, dcnt=0).
  - iClr asserted together with an acceptance: iClr wins, no pulse.
- Pulses:
  - oSwRise and oSwFall are never both 1 on a channel.
  - oSwLong may coincide with nothing else on the same channel.
- Widths:
  - dcnt is $clog2(pDebTicks+1) bits.
  - lcnt is $clog2(pLongTicks+1) bits.
  - Tick counter is $clog2(pSysClkKhz*pTickMs) bits.
- Reset mid-debounce: immediate return to OFF, outputs 0, no pulse after release.
- Channels are fully independent.

Decomposition:
- Package user_sw_pkg holds:
  - the FSM state enum (OFF, CHK_ON, ON, CHK_OFF), encoded 2-bit;
  - a width helper function;
  - default constants (clock kHz, tick ms).
- Sub-module sw_debounce_ch: one channel's synchroniser, FSM and long-press counter.
- Top: tick divider plus generate loop of pChNum sw_debounce_ch instances.

Test Plan:
All scenarios use pChNum=4, pSysClkKhz=10, pTickMs=1 (tick every 10 clocks), pDebTicks=4, pLongTicks=20, pPolMask=4'b0100.
1. Clean press: ch0 held at 1 from cycle 0 -> oSwRise[0] pulses once, oSwLevel[0]=1, within 2+4*10+1 clocks (±10 for tick phase); no other channel changes.
2. Bounce: ch1 toggled every 7 clocks for 100 clocks, then held at 1 -> no pulse during toggling; one oSwRise[1] about 40 clocks after the final edge.
3. Polarity: ch2 pin at 1 from reset, driven to 0 and held -> oSwLevel[2] goes to 1 with oSwRise[2]; pin back to 1 -> oSwFall[2] pulse.
4. Long press: ch3 held 300 clocks -> oSwLong[3] exactly one pulse, 20 ticks after entry to ON; release -> oSwFall[3]; re-press gives a fresh oSwLong.
5. Mid-operation: assert iSysRst=0 during CHK_ON on ch0 -> all outputs 0 asynchronously; after release with pin held 1, full debounce restarts from dcnt=0.
6. iClr while ch0 is ON and lcnt=10 -> oSwLevel[0]=0 next clock, no oSwFall; pin still 1 -> oSwRise after the full debounce time.
